// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 VGA timing, logo geometry and pixel/coordinate types.
package vga_pkg;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned LOGO_SIZE = 64;
    localparam int unsigned LOGO_BITS = 6;

    typedef logic [9:0] coord_t;
    typedef logic [5:0] rgb_t;
endpackage

// File: rtl/logo_motion.sv
// logo_motion: bouncing logo position/direction, bounce-driven tint and hit pulses.
module logo_motion
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT  = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACT  = vga_pkg::V_ACTIVE,
    parameter int unsigned SIZE   = vga_pkg::LOGO_SIZE,
    parameter int unsigned SPEED  = 1,
    parameter int unsigned INIT_X = 100,
    parameter int unsigned INIT_Y = 50
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_tick,
    input  logic   pause,
    output coord_t x,
    output coord_t y,
    output rgb_t   tint,
    output logic   bounce,
    output logic   corner_hit
);
    localparam coord_t X_MAX = coord_t'(H_ACT - SIZE);
    localparam coord_t Y_MAX = coord_t'(V_ACT - SIZE);
    localparam coord_t STEP  = coord_t'(SPEED);

    logic   dx, dy, x_hit, y_hit, upd;
    coord_t x_nxt, y_nxt;

    // dx/dy high means moving towards increasing coordinates
    always_comb begin
        upd   = frame_tick && !pause;
        x_hit = dx ? (x + STEP >= X_MAX) : (x <= STEP);
        y_hit = dy ? (y + STEP >= Y_MAX) : (y <= STEP);
        x_nxt = x_hit ? (dx ? X_MAX : '0) : (dx ? x + STEP : x - STEP);
        y_nxt = y_hit ? (dy ? Y_MAX : '0) : (dy ? y + STEP : y - STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= coord_t'(INIT_X);
            y          <= coord_t'(INIT_Y);
            dx         <= 1'b1;
            dy         <= 1'b1;
            tint       <= '0;
            bounce     <= 1'b0;
            corner_hit <= 1'b0;
        end else begin
            bounce     <= upd && (x_hit || y_hit);
            corner_hit <= upd && x_hit && y_hit;
            if (upd) begin
                x    <= x_nxt;
                y    <= y_nxt;
                dx   <= dx ^ x_hit;
                dy   <= dy ^ y_hit;
                tint <= tint + rgb_t'(x_hit || y_hit);
            end
        end
    end
endmodule

// File: rtl/logo_sprite_engine.sv
// logo_sprite_engine: logo ROM addressing and 2-stage pixel pipeline with tint,
// transparency and sync signals delayed to stay aligned with the colour outputs.
module logo_sprite_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT  = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACT  = vga_pkg::V_ACTIVE,
    parameter int unsigned SPEED  = 1,
    parameter int unsigned INIT_X = 100,
    parameter int unsigned INIT_Y = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        pause,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_q,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        bounce,
    output logic        corner_hit
);
    coord_t                 x, y;
    rgb_t                   tint, rgb, pix;
    logic                   frame_tick, in_sprite, s1_in, s1_de, hs1, vs1;
    logic [LOGO_BITS-1:0]   col, row;
    logic [1:0]             rom_q_unused;

    // fires once per frame in vertical blanking so the move never tears
    assign frame_tick   = vpos == coord_t'(V_ACT) && hpos == '0;
    assign rom_q_unused = rom_q[7:6];

    logo_motion #(
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .SIZE   (LOGO_SIZE),
        .SPEED  (SPEED),
        .INIT_X (INIT_X),
        .INIT_Y (INIT_Y)
    ) u_motion (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .pause      (pause),
        .x          (x),
        .y          (y),
        .tint       (tint),
        .bounce     (bounce),
        .corner_hit (corner_hit)
    );

    // low bits of the offset equal the low bits of the difference (mod 64)
    always_comb begin
        in_sprite = display_on && hpos >= x && hpos < x + coord_t'(LOGO_SIZE)
                    && vpos >= y && vpos < y + coord_t'(LOGO_SIZE);
        col       = hpos[LOGO_BITS-1:0] - x[LOGO_BITS-1:0];
        row       = vpos[LOGO_BITS-1:0] - y[LOGO_BITS-1:0];
        pix       = (s1_de && s1_in && rom_q[5:0] != '0) ? rom_q[5:0] ^ tint : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            s1_in    <= 1'b0;
            s1_de    <= 1'b0;
            hs1      <= 1'b1;
            vs1      <= 1'b1;
            rgb      <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
        end else begin
            rom_addr <= in_sprite ? {row, col} : '0;
            s1_in    <= in_sprite;
            s1_de    <= display_on;
            hs1      <= hsync_in;
            vs1      <= vsync_in;
            rgb      <= pix;
            hsync    <= hs1;
            vsync    <= vs1;
        end
    end

    assign {r, g, b} = rgb;
endmodule
